branch_resolution_unit: RTL and testbench

//  MEM-stage resolver: consumer side of the branch predictor's IF outputs.
//  - Resolves each branch/jump against the IF-stage prediction carried down the pipe.
//  - On a misprediction, drives the IF redirect and a multi-cycle front-end flush.
//  - Queues predictor training updates (BTB target + 2-bit counter) to the predictor write port.

---
 rtl/branch_resolution_unit.sv | 203 ++++++++++++++++++++
 tb/tb_branch_resolution_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
//   MEM-stage branch resolver. Compares each resolved branch or jump with the
//   prediction made at IF. On a misprediction it issues a one-cycle redirect
//   and holds a multi-cycle front-end flush. It also queues predictor training
//   updates (BTB target plus the new 2-bit counter) for the predictor write port.
//
//   Optional feature macro: BRU_STATS_EN adds the saturating statistics
//   counters stat_branches and stat_mispredicts.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mem_*                    resolved MEM-stage instruction and its IF prediction
//   upd_ready / upd_valid    update port handshake; upd_pc/target/taken/counter
//                            carry the queue head entry
//   redirect_valid/pc        one-cycle fetch redirect
//   flush                    squash IF/ID/EX
//   mem_stall                hold MEM because the update queue is full
//   stat_branches/mispredicts  statistics (BRU_STATS_EN only)
//   state_dbg                resolver FSM state (0 = IDLE, 1 = FLUSH)
//
// Handshake: an update transfers on every rising edge where upd_valid and
// upd_ready are both high; upd_valid never depends on upd_ready.
module branch_resolution_unit #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic              mem_is_branch,
   input  logic              mem_is_jump,
   input  logic [31:0]       mem_pc,
   input  logic              mem_br_en,
   input  logic [31:0]       mem_target,
   input  logic              mem_BTB_hit,
   input  logic [1:0]        mem_predicted_outcome,
   input  logic [31:0]       mem_predicted_target,
   input  logic              upd_ready,
   output logic              upd_valid,
   output logic [31:0]       upd_pc,
   output logic [31:0]       upd_target,
   output logic              upd_taken,
   output logic [1:0]        upd_counter,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic              flush,
   output logic              mem_stall,
`ifdef BRU_STATS_EN
   output logic [CNT_W-1:0]  stat_branches,
   output logic [CNT_W-1:0]  stat_mispredicts,
`endif
   output logic              state_dbg
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t            state;
   logic [FC_W-1:0]   flush_cnt;

   // Update queue storage and pointers
   logic [31:0]       q_pc     [DEPTH];
   logic [31:0]       q_target [DEPTH];
   logic              q_taken  [DEPTH];
   logic [1:0]        q_ctr    [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;

   logic              cand;
   logic              pred_taken;
   logic              act_taken;
   logic              mispredict;
   logic [31:0]       correct_pc;
   logic [1:0]        new_ctr;
   logic              needs_entry;
   logic              full;
   logic              accept;
   logic              push;
   logic              pop;

   // ---------------- Resolution ----------------
   assign cand        = mem_valid & (mem_is_branch | mem_is_jump) & (state == ST_IDLE);
   assign pred_taken  = mem_BTB_hit & mem_predicted_outcome[1];
   assign act_taken   = mem_is_jump | (mem_is_branch & mem_br_en);
   assign mispredict  = (pred_taken != act_taken) |
                        (pred_taken & act_taken & (mem_predicted_target != mem_target));
   // 32-bit add wraps naturally, so 0xFFFFFFFC + 4 gives 0
   assign correct_pc  = act_taken ? mem_target : (mem_pc + 32'd4);

   always_comb begin
      new_ctr = mem_predicted_outcome;
      if (mem_BTB_hit) begin
         if (act_taken)
            new_ctr = (mem_predicted_outcome == 2'b11) ? 2'b11 : mem_predicted_outcome + 2'b01;
         else
            new_ctr = (mem_predicted_outcome == 2'b00) ? 2'b00 : mem_predicted_outcome - 2'b01;
      end else begin
         // Fresh allocation starts weakly taken
         new_ctr = 2'b10;
      end
   end

   // A BTB miss that is not taken produces no training entry
   assign needs_entry = cand & (mem_BTB_hit | act_taken);
   // Full test deliberately ignores a same-cycle pop
   assign full        = (count == (PTR_W+1)'(DEPTH));
   assign mem_stall   = needs_entry & full;
   assign accept      = cand & ~mem_stall;
   assign push        = accept & needs_entry;
   assign pop         = upd_valid & upd_ready;

   // ---------------- Update queue ----------------
   assign upd_valid   = (count != '0);
   assign upd_pc      = upd_valid ? q_pc[rd_ptr]     : 32'd0;
   assign upd_target  = upd_valid ? q_target[rd_ptr] : 32'd0;
   assign upd_taken   = upd_valid ? q_taken[rd_ptr]  : 1'b0;
   assign upd_counter = upd_valid ? q_ctr[rd_ptr]    : 2'b00;

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]     <= mem_pc;
         q_target[wr_ptr] <= mem_target;
         q_taken[wr_ptr]  <= act_taken;
         q_ctr[wr_ptr]    <= new_ctr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------- Redirect / flush FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         flush_cnt      <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               redirect_valid <= 1'b0;
               if (accept && mispredict) begin
                  state          <= ST_FLUSH;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= correct_pc;
                  flush          <= 1'b1;
                  flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
               end
            end
            ST_FLUSH: begin
               redirect_valid <= 1'b0;
               if (flush_cnt == '0) begin
                  state <= ST_IDLE;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - FC_W'(1);
               end
            end
            default: begin
               state          <= ST_IDLE;
               flush          <= 1'b0;
               redirect_valid <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

`ifdef BRU_STATS_EN
   // ---------------- Saturating statistics ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (accept && (stat_branches != '1))
            stat_branches <= stat_branches + CNT_W'(1);
         if (accept && mispredict && (stat_mispredicts != '1))
            stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
module tb_branch_resolution_unit;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic        mem_is_branch;
   logic        mem_is_jump;
   logic [31:0] mem_pc;
   logic        mem_br_en;
   logic [31:0] mem_target;
   logic        mem_BTB_hit;
   logic [1:0]  mem_predicted_outcome;
   logic [31:0] mem_predicted_target;
   logic        upd_ready;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic [1:0]  upd_counter;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        mem_stall;
   logic        state_dbg;
`ifdef BRU_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int checks   = 0;
   int failures = 0;

   // Expected update entries {pc, target, taken, counter} and redirect PCs
   logic [66:0] exp_upd_q[$];
   logic [31:0] exp_redir_q[$];

   branch_resolution_unit dut (
      .clk                   (clk),
      .rst                   (rst),
      .mem_valid             (mem_valid),
      .mem_is_branch         (mem_is_branch),
      .mem_is_jump           (mem_is_jump),
      .mem_pc                (mem_pc),
      .mem_br_en             (mem_br_en),
      .mem_target            (mem_target),
      .mem_BTB_hit           (mem_BTB_hit),
      .mem_predicted_outcome (mem_predicted_outcome),
      .mem_predicted_target  (mem_predicted_target),
      .upd_ready             (upd_ready),
      .upd_valid             (upd_valid),
      .upd_pc                (upd_pc),
      .upd_target            (upd_target),
      .upd_taken             (upd_taken),
      .upd_counter           (upd_counter),
      .redirect_valid        (redirect_valid),
      .redirect_pc           (redirect_pc),
      .flush                 (flush),
      .mem_stall             (mem_stall),
`ifdef BRU_STATS_EN
      .stat_branches         (stat_branches),
      .stat_mispredicts      (stat_mispredicts),
`endif
      .state_dbg             (state_dbg)
   );

   // ---------------- Clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- Helpers ----------------
   task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_inputs(input logic [31:0] pc, input logic br, input logic jmp,
                             input logic br_en, input logic [31:0] tgt, input logic hit,
                             input logic [1:0] ctr, input logic [31:0] ptgt);
      mem_valid             = 1'b1;
      mem_pc                = pc;
      mem_is_branch         = br;
      mem_is_jump           = jmp;
      mem_br_en             = br_en;
      mem_target            = tgt;
      mem_BTB_hit           = hit;
      mem_predicted_outcome = ctr;
      mem_predicted_target  = ptgt;
   endtask

   // Called just after a rising edge; presents one instruction for one cycle
   task automatic issue(input logic [31:0] pc, input logic br, input logic jmp,
                        input logic br_en, input logic [31:0] tgt, input logic hit,
                        input logic [1:0] ctr, input logic [31:0] ptgt,
                        input logic exp_push, input logic [66:0] exp_entry,
                        input logic exp_mp, input logic [31:0] exp_rpc);
      if (exp_push) exp_upd_q.push_back(exp_entry);
      if (exp_mp)   exp_redir_q.push_back(exp_rpc);
      set_inputs(pc, br, jmp, br_en, tgt, hit, ctr, ptgt);
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   // ---------------- Monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (redirect_valid) begin
            if (exp_redir_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_redirect actual=0x%0h required=none", redirect_pc);
            end else begin
               chk("redirect_pc", {35'd0, redirect_pc}, {35'd0, exp_redir_q.pop_front()});
            end
         end
         if (upd_valid && upd_ready) begin
            if (exp_upd_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_update actual=0x%0h required=none",
                        {upd_pc, upd_target, upd_taken, upd_counter});
            end else begin
               chk("upd_entry", {upd_pc, upd_target, upd_taken, upd_counter}, exp_upd_q.pop_front());
            end
         end
      end
   end

   // ---------------- Stimulus ----------------
   initial begin
      int fcnt;
      rst       = 1'b1;
      upd_ready = 1'b1;
      set_inputs(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0);
      mem_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {62'd0, upd_valid, redirect_valid, flush, mem_stall, state_dbg}, 67'd0);
      chk("reset_upd_pc", {35'd0, upd_pc}, 67'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Correctly predicted taken branch: counter 2 -> 3, no redirect
      issue(32'h100, 1, 0, 1, 32'h180, 1, 2'd2, 32'h180,
            1, {32'h100, 32'h180, 1'b1, 2'd3}, 0, 32'd0);
      @(negedge clk);
      chk("t2_upd_valid_latency", {66'd0, upd_valid}, 67'd1);
      chk("t2_no_flush", {66'd0, flush}, 67'd0);
      idle_cycles(2);

      // Predicted not taken, actually taken: redirect to target, 3 flush cycles
      issue(32'h200, 1, 0, 1, 32'h240, 1, 2'd1, 32'h0,
            1, {32'h200, 32'h240, 1'b1, 2'd2}, 1, 32'h240);
      // Mispredicting jump shown during flush must be squashed
      set_inputs(32'h500, 1'b0, 1'b1, 1'b1, 32'h999, 1'b0, 2'd0, 32'd0);
      fcnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (flush) fcnt++;
         if (i == 0) chk("t3_stall_in_flush", {66'd0, mem_stall}, 67'd0);
         if (i == 1) mem_valid = 1'b0;
      end
      chk("t3_flush_cycles", 67'(fcnt), 67'd3);
      @(posedge clk);
      #1;

      // Predicted taken, actually not taken at the top of memory: pc+4 wraps to 0
      issue(32'hFFFF_FFFC, 1, 0, 0, 32'h50, 1, 2'd3, 32'h50,
            1, {32'hFFFF_FFFC, 32'h50, 1'b0, 2'd2}, 1, 32'h0);
      idle_cycles(5);

      // jalr target mismatch: counter stays saturated at 3
      issue(32'h400, 0, 1, 1, 32'h310, 1, 2'd3, 32'h300,
            1, {32'h400, 32'h310, 1'b1, 2'd3}, 1, 32'h310);
      idle_cycles(5);

      // BTB miss, not taken: nothing queued, no redirect
      issue(32'h600, 1, 0, 0, 32'h640, 0, 2'd3, 32'h0,
            0, 67'd0, 0, 32'd0);
      idle_cycles(2);

      // BTB miss, taken: allocate with counter 2 and redirect
      issue(32'h700, 1, 0, 1, 32'h740, 0, 2'd0, 32'h0,
            1, {32'h700, 32'h740, 1'b1, 2'd2}, 1, 32'h740);
      idle_cycles(5);

      // BTB hit, counter 0, not taken: saturates at 0, correct prediction
      issue(32'h800, 1, 0, 0, 32'h840, 1, 2'd0, 32'h840,
            1, {32'h800, 32'h840, 1'b0, 2'd0}, 0, 32'd0);
      idle_cycles(2);

      // Full queue: four entries with the predictor not accepting
      upd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(32'h1000 + 32'(i * 16), 1, 0, 1, 32'h2000 + 32'(i * 16), 1, 2'd2,
               32'h2000 + 32'(i * 16),
               1, {32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 1'b1, 2'd3}, 0, 32'd0);
      end
      exp_upd_q.push_back({32'h1040, 32'h2040, 1'b1, 2'd3});
      set_inputs(32'h1040, 1'b1, 1'b0, 1'b1, 32'h2040, 1'b1, 2'd2, 32'h2040);
      @(negedge clk);
      chk("t5_stall_full", {66'd0, mem_stall}, 67'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t5_stall_held", {66'd0, mem_stall}, 67'd1);
      @(posedge clk);
      #1;
      upd_ready = 1'b1;
      @(negedge clk);
      chk("t5_stall_ignores_pop", {66'd0, mem_stall}, 67'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t5_stall_released", {66'd0, mem_stall}, 67'd0);
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      idle_cycles(8);

      // Reset asserted in the middle of a flush with an entry still queued
      upd_ready = 1'b0;
      issue(32'h900, 1, 0, 1, 32'h940, 1, 2'd1, 32'h0,
            1, {32'h900, 32'h940, 1'b1, 2'd2}, 1, 32'h940);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("t1_flush_before_rst", {66'd0, flush}, 67'd1);
      rst = 1'b1;
      #1;
      chk("t1_outputs_after_rst", {62'd0, upd_valid, redirect_valid, flush, mem_stall, state_dbg}, 67'd0);
      chk("t1_upd_fields_after_rst", {upd_pc, upd_target, upd_taken, upd_counter}, 67'd0);
      exp_upd_q.delete();
      #1;
      rst = 1'b0;
      upd_ready = 1'b1;
      @(posedge clk);
      #1;
      issue(32'hA00, 0, 1, 1, 32'hA80, 0, 2'd0, 32'h0,
            1, {32'hA00, 32'hA80, 1'b1, 2'd2}, 1, 32'hA80);
      @(negedge clk);
      chk("t1_flush_after_rst", {66'd0, flush}, 67'd1);
      idle_cycles(5);

      // Drain with a bounded wait, then confirm nothing is outstanding
      for (int i = 0; i < 50 && (exp_upd_q.size() != 0 || exp_redir_q.size() != 0); i++) begin
         @(posedge clk);
      end
      #1;
      chk("drain_upd_q", 67'(exp_upd_q.size()), 67'd0);
      chk("drain_redir_q", 67'(exp_redir_q.size()), 67'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
